// File: rtl/core_run_sequencer.sv
// Run sequencer for the HlangPU core: reset pulse, entry-address load, then
// continuous or single-step execute enable until halt, fault, timeout or abort.
module core_run_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARSTN,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 MODE,
  input  logic                 STEP,
  input  logic [31:0]          ENTRY_ADDR,
  input  logic [CNT_WIDTH-1:0] CYCLE_LIMIT,
  input  logic [15:0]          CSTAT,
  output logic                 CRST,
  output logic                 CEXEC,
  output logic [31:0]          CMEM_ADDR,
  output logic                 BUSY,
  output logic                 DONE_HALT,
  output logic                 DONE_FAULT,
  output logic                 DONE_TIMEOUT,
  output logic                 DONE_ABORT,
  output logic [CNT_WIDTH-1:0] CYCLES,
  output logic [2:0]           STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_ARM       = 3'd2,
    S_RUN       = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_STEP_EXEC = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam int                   RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [RC_W-1:0]      RC_ONE   = RC_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   CNT_ONEX = (CNT_WIDTH + 1)'(1);

  // Done flag vector order: {halt, fault, timeout, abort}
  localparam logic [3:0] END_HALT    = 4'b1000;
  localparam logic [3:0] END_FAULT   = 4'b0100;
  localparam logic [3:0] END_TIMEOUT = 4'b0010;
  localparam logic [3:0] END_ABORT   = 4'b0001;

  state_t                r_state;
  logic [RC_W-1:0]       r_rst_cnt;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_limit;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic [31:0]           r_addr;
  logic                  r_crst;
  logic                  r_cexec;
  logic                  r_busy;
  logic [3:0]            r_done;

  logic [CNT_WIDTH-1:0]  w_cycles_inc;
  logic                  w_limit_hit;
  logic [3:0]            w_stop;
  logic                  w_unused_cstat;

  assign w_unused_cstat = ^CSTAT[15:2];

  // Counter saturates; the limit compare is done one bit wider so it cannot wrap.
  assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + CNT_ONE;
  assign w_limit_hit  = (r_limit != '0) &&
                        (({1'b0, r_cycles} + CNT_ONEX) == {1'b0, r_limit});

  always_comb begin
    w_stop = 4'b0000;
    if (ABORT)         w_stop = END_ABORT;
    else if (CSTAT[1]) w_stop = END_FAULT;
    else if (CSTAT[0]) w_stop = END_HALT;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARSTN) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= '0;
      r_mode    <= 1'b0;
      r_limit   <= '0;
      r_cycles  <= '0;
      r_addr    <= '0;
      r_crst    <= 1'b0;
      r_cexec   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_addr    <= ENTRY_ADDR;
            r_mode    <= MODE;
            r_limit   <= CYCLE_LIMIT;
            r_cycles  <= '0;
            r_done    <= '0;
            r_rst_cnt <= '0;
            r_crst    <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RESET;
          end
        end
        S_RESET: begin
          if (ABORT) begin
            r_crst  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= END_ABORT;
            r_state <= S_DONE;
          end else if (r_rst_cnt == RST_LAST) begin
            r_crst  <= 1'b0;
            r_state <= S_ARM;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_ONE;
          end
        end
        S_ARM: begin
          if (ABORT) begin
            r_busy  <= 1'b0;
            r_done  <= END_ABORT;
            r_state <= S_DONE;
          end else if (r_mode) begin
            r_state <= S_STEP_WAIT;
          end else begin
            r_cexec <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycles <= w_cycles_inc;
          if (w_stop != 4'b0000 || w_limit_hit) begin
            r_cexec <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= (w_stop != 4'b0000) ? w_stop : END_TIMEOUT;
            r_state <= S_DONE;
          end
        end
        S_STEP_WAIT: begin
          if (w_stop != 4'b0000) begin
            r_busy  <= 1'b0;
            r_done  <= w_stop;
            r_state <= S_DONE;
          end else if (STEP) begin
            r_cexec <= 1'b1;
            r_state <= S_STEP_EXEC;
          end
        end
        S_STEP_EXEC: begin
          // Any STEP seen here is deliberately dropped.
          r_cycles <= w_cycles_inc;
          r_cexec  <= 1'b0;
          if (ABORT || w_limit_hit) begin
            r_busy  <= 1'b0;
            r_done  <= ABORT ? END_ABORT : END_TIMEOUT;
            r_state <= S_DONE;
          end else begin
            r_state <= S_STEP_WAIT;
          end
        end
        default: begin
          r_cexec <= 1'b0;
          r_crst  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign CRST         = r_crst;
  assign CEXEC        = r_cexec;
  assign CMEM_ADDR    = r_addr;
  assign BUSY         = r_busy;
  assign DONE_HALT    = r_done[3];
  assign DONE_FAULT   = r_done[2];
  assign DONE_TIMEOUT = r_done[1];
  assign DONE_ABORT   = r_done[0];
  assign CYCLES       = r_cycles;
  assign STATE        = r_state;

endmodule
